mem_port_arbiter: RTL and testbench

Shares one single-port, variable-latency memory between instruction fetch and the data load/store path of the core. It decodes nothing itself. Requests from the fetch unit and from the datapath's memory stage (driven by MemRw and byte enables) are arbitrated, one transaction is kept outstanding at a time, and the response is routed back to its owner. It sits between the core and the unified memory, and its `stall` output freezes the PC and pipeline registers while an access is pending.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_arb_pick.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 tb/tb_mem_port_arbiter.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the instruction/data memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

    localparam int DEF_TIMEOUT      = 255;
    localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and unified-memory signals of the shared memory port
interface mem_port_arbiter_if #(
    parameter int XLEN = 32
);
    logic              if_req;
    logic [XLEN-1:0]   if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [XLEN-1:0]   if_rdata;

    logic              d_req;
    logic              d_we;
    logic [XLEN-1:0]   d_addr;
    logic [XLEN-1:0]   d_wdata;
    logic [XLEN/8-1:0] d_be;
    logic              d_gnt;
    logic              d_rvalid;
    logic [XLEN-1:0]   d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_be;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;

    logic              stall;
    logic              bus_err;

    // master: the arbiter's view; slave: the core and memory around it
    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
        input  mem_ready, mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be, stall, bus_err
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
        output mem_ready, mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be, stall, bus_err
    );

endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - data-first winner selection with a fetch anti-starvation streak counter
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   if_req,
    input  logic   d_req,
    input  logic   idle,
    input  logic   grant,
    output owner_t owner
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] streak;
    logic          force_if;

    assign force_if = if_req && (streak == LIMIT);
    assign owner    = (d_req && !force_if) ? OWN_D : OWN_IF;

    // streak only counts data grants taken while fetch was left waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= '0;
        end else if (grant && (owner == OWN_IF)) begin
            streak <= '0;
        end else if (grant && if_req) begin
            if (streak != LIMIT) begin
                streak <= streak + 1'b1;
            end
        end else if (idle && !if_req) begin
            streak <= '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - one-outstanding arbiter sharing a unified memory between fetch and data
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.master  bus
);

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t          state;
    owner_t          owner_q;
    owner_t          win;
    logic [7:0]      tcnt;
    logic [XLEN-1:0] rdata_q;
    logic            if_rvalid_q;
    logic            d_rvalid_q;
    logic            bus_err_q;

    logic            idle;
    logic            req_out;
    logic            grant;
    logic            pick_d;

    assign idle    = (state == S_IDLE);
    assign req_out = rst_n && idle && (bus.if_req || bus.d_req);
    assign grant   = req_out && bus.mem_ready;
    assign pick_d  = (win == OWN_D);

    mem_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .clk    (clk),
        .rst_n  (rst_n),
        .if_req (bus.if_req),
        .d_req  (bus.d_req),
        .idle   (idle),
        .grant  (grant),
        .owner  (win)
    );

    // payload is forced to zero whenever no request is presented, including during reset
    assign bus.mem_req   = req_out;
    assign bus.mem_we    = req_out && pick_d && bus.d_we;
    assign bus.mem_addr  = !req_out ? '0 : (pick_d ? bus.d_addr : bus.if_addr);
    assign bus.mem_wdata = (req_out && pick_d) ? bus.d_wdata : '0;
    assign bus.mem_be    = !req_out ? '0 : (pick_d ? bus.d_be : '1);

    assign bus.if_gnt    = grant && !pick_d;
    assign bus.d_gnt     = grant && pick_d;
    assign bus.stall     = rst_n && (bus.if_req || bus.d_req || !idle);

    assign bus.if_rvalid = if_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.if_rdata  = rdata_q;
    assign bus.d_rdata   = rdata_q;
    assign bus.bus_err   = bus_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            owner_q     <= OWN_IF;
            tcnt        <= '0;
            rdata_q     <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        owner_q <= win;
                        tcnt    <= '0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // a real response beats a timeout landing in the same cycle
                    if (bus.mem_rvalid) begin
                        rdata_q     <= bus.mem_rdata;
                        if_rvalid_q <= (owner_q == OWN_IF);
                        d_rvalid_q  <= (owner_q == OWN_D);
                        state       <= S_RESP;
                    end else if (tcnt == TMO) begin
                        rdata_q     <= '0;
                        bus_err_q   <= 1'b1;
                        if_rvalid_q <= (owner_q == OWN_IF);
                        d_rvalid_q  <= (owner_q == OWN_D);
                        state       <= S_RESP;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for the fetch/data memory port arbiter
module tb_mem_port_arbiter;

    localparam int XLEN = 32;

    typedef struct packed {
        logic            own_d;
        logic [XLEN-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [XLEN-1:0] mon_data;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.XLEN(XLEN)) bus ();

    mem_port_arbiter #(
        .XLEN(XLEN),
        .STARVE_LIMIT(4),
        .TIMEOUT(255)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // every response pulse is matched against the next expected response
    always @(negedge clk) begin
        if (rst_n && (bus.if_rvalid || bus.d_rvalid)) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL resp_unexpected: if_rvalid=%0b d_rvalid=%0b, required no response",
                         bus.if_rvalid, bus.d_rvalid);
            end else begin
                mon_e    = sb.pop_front();
                mon_data = mon_e.own_d ? bus.d_rdata : bus.if_rdata;
                if (bus.d_rvalid !== mon_e.own_d || bus.if_rvalid !== !mon_e.own_d ||
                    mon_data !== mon_e.data) begin
                    bad++;
                    $display("FAIL resp_match: d_rvalid=%0b if_rvalid=%0b data=%h, required d=%0b data=%h",
                             bus.d_rvalid, bus.if_rvalid, mon_data, mon_e.own_d, mon_e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.d_req      = 1'b0;
        bus.d_we       = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.d_be       = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    task automatic push_exp(input logic own_d, input logic [XLEN-1:0] data);
        exp_t e;
        e.own_d = own_d;
        e.data  = data;
        sb.push_back(e);
    endtask

    // called in the first WAIT cycle; returns in the RESP cycle
    task automatic respond(input logic own_d, input logic [XLEN-1:0] data, input int delay);
        repeat (delay) step();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = data;
        push_exp(own_d, data);
        step();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    function automatic logic [205:0] all_outs();
        return {bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_rvalid, bus.d_rdata,
                bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be,
                bus.stall, bus.bus_err};
    endfunction

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (all_outs() !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h, required 0", all_outs());
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_load();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100; bus.d_be = 4'hf;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.d_gnt, bus.if_gnt, bus.mem_req, bus.mem_we, bus.mem_addr} !== {4'b1010, 32'h100}) begin
            bad++;
            $display("FAIL load_grant: d_gnt=%0b if_gnt=%0b req=%0b we=%0b addr=%h, required 1 0 1 0 100",
                     bus.d_gnt, bus.if_gnt, bus.mem_req, bus.mem_we, bus.mem_addr);
        end
        step();
        bus.d_req = 1'b0; bus.mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.mem_req, bus.stall, bus.d_rvalid} !== 3'b010) begin
            bad++;
            $display("FAIL load_wait: req=%0b stall=%0b d_rvalid=%0b, required 0 1 0",
                     bus.mem_req, bus.stall, bus.d_rvalid);
        end
        step();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        push_exp(1'b1, 32'hDEADBEEF);
        @(negedge clk);
        total++;
        if (bus.d_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL load_early_rvalid: d_rvalid=%0b, required 0", bus.d_rvalid);
        end
        step();
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        @(negedge clk);
        total++;
        if ({bus.d_rvalid, bus.if_rvalid, bus.d_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL load_resp: d_rvalid=%0b if_rvalid=%0b d_rdata=%h, required 1 0 deadbeef",
                     bus.d_rvalid, bus.if_rvalid, bus.d_rdata);
        end
        step();
        @(negedge clk);
        total++;
        if ({bus.d_rvalid, bus.stall} !== 2'b00) begin
            bad++;
            $display("FAIL load_done: d_rvalid=%0b stall=%0b, required 0 0", bus.d_rvalid, bus.stall);
        end
        step();
    endtask

    task automatic test_collision();
        bus.if_req = 1'b1; bus.if_addr = 32'h200;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h300; bus.d_be = 4'h3;
        bus.d_wdata = 32'h0BADF00D; bus.mem_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.d_gnt, bus.if_gnt, bus.stall, bus.mem_addr} !== {3'b101, 32'h300}) begin
            bad++;
            $display("FAIL coll_first: d_gnt=%0b if_gnt=%0b stall=%0b addr=%h, required 1 0 1 300",
                     bus.d_gnt, bus.if_gnt, bus.stall, bus.mem_addr);
        end
        step();
        bus.d_req = 1'b0;
        respond(1'b1, 32'h0000A5A5, 0);
        @(negedge clk);
        total++;
        if ({bus.stall, bus.if_gnt, bus.d_rvalid} !== 3'b101) begin
            bad++;
            $display("FAIL coll_resp: stall=%0b if_gnt=%0b d_rvalid=%0b, required 1 0 1",
                     bus.stall, bus.if_gnt, bus.d_rvalid);
        end
        step();
        @(negedge clk);
        total++;
        if ({bus.if_gnt, bus.stall, bus.mem_we, bus.mem_be, bus.mem_addr} !== {3'b110, 4'hf, 32'h200}) begin
            bad++;
            $display("FAIL coll_fetch: if_gnt=%0b stall=%0b we=%0b be=%h addr=%h, required 1 1 0 f 200",
                     bus.if_gnt, bus.stall, bus.mem_we, bus.mem_be, bus.mem_addr);
        end
        step();
        bus.if_req = 1'b0; bus.d_we = 1'b0;
        respond(1'b0, 32'h11112222, 1);
        @(negedge clk);
        total++;
        if ({bus.if_rvalid, bus.stall} !== 2'b11) begin
            bad++;
            $display("FAIL coll_fetch_resp: if_rvalid=%0b stall=%0b, required 1 1", bus.if_rvalid, bus.stall);
        end
        step();
    endtask

    task automatic test_store();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h400; bus.d_be = 4'b0011;
        bus.d_wdata = 32'h12345678; bus.mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.d_gnt, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_wdata} !== {3'b011, 4'b0011, 32'h12345678}) begin
            bad++;
            $display("FAIL store_not_ready: gnt=%0b req=%0b we=%0b be=%b wdata=%h, required 0 1 1 0011 12345678",
                     bus.d_gnt, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_wdata);
        end
        step();
        bus.mem_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.d_gnt, bus.mem_we, bus.mem_be, bus.mem_wdata, bus.mem_addr} !== {2'b11, 4'b0011, 32'h12345678, 32'h400}) begin
            bad++;
            $display("FAIL store_grant: gnt=%0b we=%0b be=%b wdata=%h addr=%h, required 1 1 0011 12345678 400",
                     bus.d_gnt, bus.mem_we, bus.mem_be, bus.mem_wdata, bus.mem_addr);
        end
        step();
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        respond(1'b1, 32'h0, 2);
        @(negedge clk);
        total++;
        if (bus.d_rvalid !== 1'b1) begin
            bad++;
            $display("FAIL store_ack: d_rvalid=%0b, required 1", bus.d_rvalid);
        end
        step();
    endtask

    task automatic test_starvation();
        int   gnt_cyc[6];
        logic gnt_d[6];
        logic exp_d[6];
        int   n;
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        n = 0;
        for (int i = 0; i < 6; i++) push_exp(exp_d[i], 32'hCAFEF00D);
        bus.if_req = 1'b1; bus.if_addr = 32'h600;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h700; bus.d_be = 4'hf;
        bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
        for (int c = 0; c < 60 && n < 6; c++) begin
            @(negedge clk);
            if (bus.if_gnt || bus.d_gnt) begin
                gnt_cyc[n] = c;
                gnt_d[n]   = bus.d_gnt;
                n++;
            end
            step();
            if (n > 0 && !gnt_d[n-1]) bus.if_req = 1'b0;
        end
        bus.d_req = 1'b0;
        step();
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        step();
        total++;
        if (n != 6) begin
            bad++;
            $display("FAIL starve_count: grants=%0d, required 6", n);
        end
        for (int i = 0; i < n; i++) begin
            total++;
            if (gnt_d[i] !== exp_d[i]) begin
                bad++;
                $display("FAIL starve_order[%0d]: d_gnt=%0b, required %0b", i, gnt_d[i], exp_d[i]);
            end
        end
        for (int i = 1; i < n; i++) begin
            total++;
            if (gnt_cyc[i] - gnt_cyc[i-1] != 3) begin
                bad++;
                $display("FAIL starve_spacing[%0d]: %0d cycles, required 3", i, gnt_cyc[i] - gnt_cyc[i-1]);
            end
        end
    endtask

    task automatic test_timeout();
        int hit;
        hit = -1;
        bus.if_req = 1'b1; bus.if_addr = 32'h500; bus.mem_ready = 1'b1;
        @(negedge clk);
        total++;
        if (bus.if_gnt !== 1'b1) begin
            bad++;
            $display("FAIL tmo_grant: if_gnt=%0b, required 1", bus.if_gnt);
        end
        step();
        bus.if_req = 1'b0;
        push_exp(1'b0, 32'h0);
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (bus.bus_err || bus.if_rvalid || bus.d_rvalid) begin
                hit = c;
                break;
            end
            step();
        end
        total++;
        if (hit != 257 || {bus.bus_err, bus.if_rvalid, bus.if_rdata} !== {2'b11, 32'h0}) begin
            bad++;
            $display("FAIL tmo_pulse: cycle=%0d bus_err=%0b if_rvalid=%0b rdata=%h, required 257 1 1 0",
                     hit, bus.bus_err, bus.if_rvalid, bus.if_rdata);
        end
        step();
        @(negedge clk);
        total++;
        if (bus.bus_err !== 1'b0) begin
            bad++;
            $display("FAIL tmo_pulse_width: bus_err=%0b, required 0", bus.bus_err);
        end
        step();
        step();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD0BAD0;
        step();
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        @(negedge clk);
        total++;
        if ({bus.if_rvalid, bus.d_rvalid, bus.stall} !== 3'b000) begin
            bad++;
            $display("FAIL tmo_late_rvalid: if_rvalid=%0b d_rvalid=%0b stall=%0b, required 0 0 0",
                     bus.if_rvalid, bus.d_rvalid, bus.stall);
        end
        step();
    endtask

    task automatic test_timeout_tie();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h800; bus.mem_ready = 1'b1;
        @(negedge clk);
        total++;
        if (bus.d_gnt !== 1'b1) begin
            bad++;
            $display("FAIL tie_grant: d_gnt=%0b, required 1", bus.d_gnt);
        end
        step();
        bus.d_req = 1'b0;
        repeat (255) step();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h77770001;
        push_exp(1'b1, 32'h77770001);
        @(negedge clk);
        total++;
        if ({bus.bus_err, bus.d_rvalid} !== 2'b00) begin
            bad++;
            $display("FAIL tie_early: bus_err=%0b d_rvalid=%0b, required 0 0", bus.bus_err, bus.d_rvalid);
        end
        step();
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        @(negedge clk);
        total++;
        if ({bus.bus_err, bus.d_rvalid, bus.d_rdata} !== {2'b01, 32'h77770001}) begin
            bad++;
            $display("FAIL tie_data_wins: bus_err=%0b d_rvalid=%0b rdata=%h, required 0 1 77770001",
                     bus.bus_err, bus.d_rvalid, bus.d_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h900; bus.mem_ready = 1'b1;
        @(negedge clk);
        step();
        bus.d_req = 1'b0;
        @(negedge clk);
        total++;
        if (bus.stall !== 1'b1) begin
            bad++;
            $display("FAIL rst_inflight: stall=%0b, required 1", bus.stall);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (all_outs() !== '0) begin
            bad++;
            $display("FAIL rst_async: outputs=%h, required 0", all_outs());
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFEEDFACE;
        step();
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        @(negedge clk);
        total++;
        if ({bus.if_rvalid, bus.d_rvalid, bus.stall} !== 3'b000) begin
            bad++;
            $display("FAIL rst_stray: if_rvalid=%0b d_rvalid=%0b stall=%0b, required 0 0 0",
                     bus.if_rvalid, bus.d_rvalid, bus.stall);
        end
        step();
        bus.if_req = 1'b1; bus.if_addr = 32'hA00;
        @(negedge clk);
        total++;
        if ({bus.if_gnt, bus.mem_addr} !== {1'b1, 32'hA00}) begin
            bad++;
            $display("FAIL rst_regrant: if_gnt=%0b addr=%h, required 1 a00", bus.if_gnt, bus.mem_addr);
        end
        step();
        bus.if_req = 1'b0;
        respond(1'b0, 32'h00005A5A, 0);
        @(negedge clk);
        total++;
        if ({bus.if_rvalid, bus.if_rdata} !== {1'b1, 32'h00005A5A}) begin
            bad++;
            $display("FAIL rst_regrant_resp: if_rvalid=%0b rdata=%h, required 1 00005a5a",
                     bus.if_rvalid, bus.if_rdata);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_collision();
        test_store();
        test_starvation();
        test_timeout();
        test_timeout_tie();
        test_reset_mid();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d responses outstanding, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
